// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDUop encodings and latency defaults for the multiply/divide unit
package mdu_pkg;
    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    function automatic logic is_md_op(input logic [3:0] op);
        return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
    endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage bundle between pipeline and mdu
//   MDUop/A/B : decoded op and forwarded rs/rt operands into the unit
//   start/busy: stall-unit hooks
//   HI/LO     : architectural HI/LO registers
//   MDUout    : mfhi/mflo read data (0 for any other op)
interface mdu_if;
    logic [3:0]  MDUop;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUout;
    modport master (output MDUop, A, B, input start, busy, HI, LO, MDUout);
    modport slave  (input MDUop, A, B, output start, busy, HI, LO, MDUout);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with private HI/LO
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : mdu_if slave (MDUop, A, B in; start, busy, HI, LO, MDUout out)
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);
    logic        busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        start;
    logic        is_mul, is_sgn, div_zero;
    logic signed [32:0] sa, sb, quo, rem;
    logic signed [63:0] prod;
    logic [63:0] result;
    logic        unused_ok;

    // 33-bit operands make signed and unsigned forms share one operator,
    // and hold +2^31 so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    // A zero divisor is replaced by 1 so no X is ever computed.
    always_comb begin
        is_mul   = bus.MDUop == OP_MULT || bus.MDUop == OP_MULTU;
        is_sgn   = bus.MDUop == OP_MULT || bus.MDUop == OP_DIV;
        div_zero = bus.B == 32'd0;
        sa       = {is_sgn & bus.A[31], bus.A};
        sb       = div_zero && !is_mul ? 33'sd1 : {is_sgn & bus.B[31], bus.B};
        prod     = 64'(sa) * 64'(sb);
        quo      = sa / sb;
        rem      = sa % sb;
        // divide by zero re-commits the current HI/LO, leaving them unchanged
        result   = is_mul ? prod : div_zero ? {hi_q, lo_q} : {rem[31:0], quo[31:0]};
    end
    assign unused_ok = ^{quo[32], rem[32]};

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= 4'd0;
            res_q  <= 64'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            res_d  = result;
        end else if (busy_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                cnt_d  = 4'd0;
                hi_d   = res_q[63:32];
                lo_d   = res_q[31:0];
            end
        end else begin
            hi_d = bus.MDUop == OP_MTHI ? bus.A : hi_q;
            lo_d = bus.MDUop == OP_MTLO ? bus.A : lo_q;
        end
    end

    always_comb begin
        start      = is_md_op(bus.MDUop) && !busy_q;
        bus.start  = start;
        bus.busy   = busy_q;
        bus.HI     = hi_q;
        bus.LO     = lo_q;
        bus.MDUout = bus.MDUop == OP_MFHI ? hi_q : bus.MDUop == OP_MFLO ? lo_q : 32'd0;
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu
module tb_mdu;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    mdu_if bus ();
    mdu dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic finish_op(output int cyc);
        @(posedge clk);
        @(negedge clk);
        bus.MDUop = 4'd0;
        cyc = 0;
        while (bus.busy && cyc < 30) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.MDUop = 4'd0;
        bus.A = 32'd0;
        bus.B = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want %h", bus.HI, 32'd0); end
        n_cmp++; if (bus.LO !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want %h", bus.LO, 32'd0); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", bus.start); end
        n_cmp++; if (bus.MDUout !== 32'd0) begin n_bad++; $display("FAIL reset_mduout: got %h want 0", bus.MDUout); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int cyc;
        bus.MDUop = 4'd1; bus.A = 32'hFFFFFFFE; bus.B = 32'd3;
        #1;
        n_cmp++; if (bus.start !== 1'b1) begin n_bad++; $display("FAIL mult_start: got %b want 1", bus.start); end
        n_cmp++; if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL mult_hi_early: got %h want 0", bus.HI); end
        finish_op(cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL mult_busy_cycles: got %0d want 5", cyc); end
        n_cmp++; if (bus.HI !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi: got %h want FFFFFFFF", bus.HI); end
        n_cmp++; if (bus.LO !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_lo: got %h want FFFFFFFA", bus.LO); end
        bus.MDUop = 4'd6;
        #1;
        n_cmp++; if (bus.MDUout !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_mflo: got %h want FFFFFFFA", bus.MDUout); end
        bus.MDUop = 4'd0;
    endtask

    task automatic test_multu();
        int cyc;
        bus.MDUop = 4'd2; bus.A = 32'hFFFFFFFF; bus.B = 32'd2;
        finish_op(cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL multu_busy_cycles: got %0d want 5", cyc); end
        n_cmp++; if (bus.HI !== 32'h00000001) begin n_bad++; $display("FAIL multu_hi: got %h want 00000001", bus.HI); end
        n_cmp++; if (bus.LO !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_lo: got %h want FFFFFFFE", bus.LO); end
    endtask

    task automatic test_div();
        int cyc;
        bus.MDUop = 4'd3; bus.A = 32'hFFFFFFF9; bus.B = 32'd2;
        finish_op(cyc);
        n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL div_busy_cycles: got %0d want 10", cyc); end
        n_cmp++; if (bus.LO !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo: got %h want FFFFFFFD", bus.LO); end
        n_cmp++; if (bus.HI !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi: got %h want FFFFFFFF", bus.HI); end
        bus.MDUop = 4'd4; bus.A = 32'hFFFFFFF9; bus.B = 32'd2;
        finish_op(cyc);
        n_cmp++; if (bus.LO !== 32'h7FFFFFFC) begin n_bad++; $display("FAIL divu_lo: got %h want 7FFFFFFC", bus.LO); end
        n_cmp++; if (bus.HI !== 32'h00000001) begin n_bad++; $display("FAIL divu_hi: got %h want 00000001", bus.HI); end
        bus.MDUop = 4'd3; bus.A = 32'h80000000; bus.B = 32'hFFFFFFFF;
        finish_op(cyc);
        n_cmp++; if (bus.LO !== 32'h80000000) begin n_bad++; $display("FAIL div_ovf_lo: got %h want 80000000", bus.LO); end
        n_cmp++; if (bus.HI !== 32'h00000000) begin n_bad++; $display("FAIL div_ovf_hi: got %h want 00000000", bus.HI); end
    endtask

    task automatic test_div0();
        int cyc;
        bus.MDUop = 4'd7; bus.A = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus.MDUop = 4'd5;
        #1;
        n_cmp++; if (bus.MDUout !== 32'h12345678) begin n_bad++; $display("FAIL mthi_mfhi: got %h want 12345678", bus.MDUout); end
        bus.MDUop = 4'd3; bus.A = 32'd5; bus.B = 32'd0;
        finish_op(cyc);
        n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL div0_busy_cycles: got %0d want 10", cyc); end
        n_cmp++; if (bus.HI !== 32'h12345678) begin n_bad++; $display("FAIL div0_hi: got %h want 12345678", bus.HI); end
        n_cmp++; if (bus.LO !== 32'h80000000) begin n_bad++; $display("FAIL div0_lo: got %h want 80000000", bus.LO); end
        bus.MDUop = 4'd5;
        #1;
        n_cmp++; if (bus.MDUout !== 32'h12345678) begin n_bad++; $display("FAIL div0_mfhi: got %h want 12345678", bus.MDUout); end
        bus.MDUop = 4'd0;
    endtask

    task automatic test_reset_mid();
        bus.MDUop = 4'd1; bus.A = 32'd6; bus.B = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.MDUop = 4'd0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        bus.MDUop = 4'd5;
        #1;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.MDUout !== 32'h12345678) begin n_bad++; $display("FAIL mid_mfhi_old: got %h want 12345678", bus.MDUout); end
        bus.MDUop = 4'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL mid_reset_hi: got %h want 0", bus.HI); end
        n_cmp++; if (bus.LO !== 32'd0) begin n_bad++; $display("FAIL mid_reset_lo: got %h want 0", bus.LO); end
        repeat (8) @(negedge clk);
        n_cmp++; if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL mid_late_hi: got %h want 0", bus.HI); end
        n_cmp++; if (bus.LO !== 32'd0) begin n_bad++; $display("FAIL mid_late_lo: got %h want 0", bus.LO); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus.MDUop = 4'd1; bus.A = 32'd2; bus.B = 32'd3;
        #1;
        n_cmp++; if (bus.start !== 1'b1) begin n_bad++; $display("FAIL b2b_start1: got %b want 1", bus.start); end
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
        while (bus.busy && cyc < 30) begin
            cyc++;
            n_cmp++; if (bus.start !== 1'b0) begin n_bad++; $display("FAIL b2b_start_busy: got %b want 0 in busy cycle %0d", bus.start, cyc); end
            @(negedge clk);
        end
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 5", cyc); end
        n_cmp++; if (bus.start !== 1'b1) begin n_bad++; $display("FAIL b2b_start2: got %b want 1", bus.start); end
        n_cmp++; if (bus.LO !== 32'd6) begin n_bad++; $display("FAIL b2b_lo1: got %h want 6", bus.LO); end
        bus.B = 32'd4;
        finish_op(cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL b2b_busy_cycles2: got %0d want 5", cyc); end
        n_cmp++; if (bus.LO !== 32'd8) begin n_bad++; $display("FAIL b2b_lo2: got %h want 8", bus.LO); end
        n_cmp++; if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL b2b_hi2: got %h want 0", bus.HI); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div0();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the E stage of the 5-stage pipeline. Executes `mult`, `multu`, `div` and `divu` over several cycles into private HI/LO registers, and serves `mfhi`, `mflo`, `mthi` and `mtlo`. It exports `start` and `busy` to the stall unit, which holds any multiply/divide-class instruction in D while either signal is high.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `MDUop` in 4: decoded op for the instruction in E.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
  - Codes 9–15 behave as none.
- `A` in 32: rs operand after forwarding.
- `B` in 32: rt operand after forwarding.
- `start` out 1: combinational; `MDUop` in 1..4 && !`busy`.
- `busy` out 1: registered; an operation is in flight.
- `HI` out 32: registered HI.
- `LO` out 32: registered LO.
- `MDUout` out 32: combinational.
  - `HI` for mfhi, `LO` for mflo, 0 otherwise.

## Operation
- **States:** IDLE and RUN, encoded by `busy`. Down-counter `cnt` is 4 bits; its reset value is 0.
- **IDLE, `start`=1:**
  - Latch the 64-bit result into `res_hi`/`res_lo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`; set `busy`=1.
  - `HI`/`LO` are unchanged this edge.
- **RUN:**
  - Each edge decrements `cnt`.
  - On the edge where `cnt`==1: `HI`←`res_hi`, `LO`←`res_lo`, `busy`←0, `cnt`←0.
- **Arithmetic:**
  - mult: signed 32×32 to 64 bits; HI = [63:32], LO = [31:0].
  - multu: unsigned 32×32 to 64 bits.
  - div/divu: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend `A`.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **Divide by zero (`B`=0):** runs the full `DIV_CYCLES` with `busy`; `HI`/`LO` are left unchanged at completion.
- **mthi/mtlo:** when !`busy`, `HI`←`A` or `LO`←`A` at the edge. Ignored while `busy`.
- **mfhi/mflo:** combinational read of the current `HI`/`LO`, never the pending result.
- **New mult/div while `busy`:** `start`=0, so the op is ignored. The stall unit must prevent this.
- **Reset mid-operation:** `HI`=`LO`=0, `busy`=0, `cnt`=0; the pending result is discarded.
- **Reset values:** `HI`=0, `LO`=0, `busy`=0, `start`=0 (once `MDUop` is 0), `MDUout`=0.

## Timing
- mult issued in E at cycle T (`start`=1 in T):
  - `busy`=1 in cycles T+1..T+5.
  - `HI`/`LO` are new and `busy`=0 from T+6.
- div: `busy` in T+1..T+10; results visible from T+11.
- An mfhi reaching E at T+6 or later reads the new value.
- The stall unit stalls D in cycles T..T+5, covering `start` in T and `busy` in T+1..T+5.
- Back-to-back: a second mult may start in T+6, the first cycle with `busy`=0.
- mthi at cycle T: `MDUout` for an mfhi in T+1 is `A` from T.

## Structure
- `MDUop` codes go in the shared macro/define file already used by CONTROLLER.
- The controller gains an `MDUop` output plus an `md` class flag for the stall unit.
- No sub-module: a single `mdu` using `*`, `/` and `%` on 33/64-bit sign- or zero-extended operands.
  - The multi-cycle latency is modelled by `cnt` only.

## Test plan
- Reset, then mult A=0xFFFFFFFE (−2), B=3:
  - `busy` high exactly 5 cycles.
  - Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2: after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2:
  - `busy` for 10 cycles.
  - LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- mthi A=0x12345678, then a div with B=0:
  - After 10 cycles HI stays 0x12345678.
  - mfhi `MDUout`=0x12345678.
- mult 6×7, then mfhi in the 3rd busy cycle:
  - `MDUout` = old HI.
  - `reset` asserted in the 4th busy cycle: `busy`=0, HI=LO=0 next cycle, and no later write.
- mult and a second mult held back-to-back:
  - `start` is 0 throughout `busy`.
  - The second `start` pulses in the first cycle after `busy` falls.
